kvazaar_result_ready_gen: RTL and testbench
===========================================

Name: kvazaar_result_ready_gen

Overview:
- Upstream producer of the 2-bit result-ready status consumed by the CPU-side edge-capture PIO (bits 1:0 = result banks 0/1).
- Arbitrates the accelerator's access to two ping-pong result banks.
- Raises a level-mode ready bit per completed bank and releases the bank on a CPU acknowledge.
- Guarantees a minimum low gap between ready pulses so the PIO's two-flop rising-edge detector never misses a re-assertion.

Parameters:
- NUM_BANKS, 2: number of result banks. Fixed to 2 to match the PIO width; other values unsupported.
- MIN_LOW, 2: minimum cycles a ready bit stays low after release before the bank can be re-granted. Must be ≥2.
- TIMEOUT_CYC, 1048576: READY-state watchdog limit (only with the optional feature).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous assert, active-low
- acc_req  in  1  accelerator requests a free bank (level, held until grant)
- acc_grant  out  1  one-cycle grant pulse
- acc_grant_bank  out  1  bank index valid with acc_grant
- acc_done  in  1  one-cycle pulse: granted bank fully written
- cpu_ack  in  2  per-bank acknowledge level from the CPU-written PIO; a rising edge releases the bank
- result_ready  out  2  per-bank ready level to the edge-capture PIO in_port
- acc_stall  out  1  high when acc_req is pending and no bank is grantable
- proto_err  out  1  sticky: acc_done with no BUSY bank
- ack_err  out  1  sticky: ack rising edge on a bank that is not READY
- timeout  out  2  sticky per bank, optional feature only (tied 0 otherwise)

Behaviour:
- All outputs registered. Reset values:
  - acc_grant=0, acc_grant_bank=0, result_ready=0, acc_stall=0.
  - proto_err=0, ack_err=0, timeout=0.
  - All banks FREE, wr_ptr=0, ack_d=0.
- Per-bank FSM: FREE -> BUSY -> READY -> HOLDOFF -> FREE.
  - FREE->BUSY on grant.
  - BUSY->READY on acc_done.
  - READY->HOLDOFF on ack rising edge.
  - HOLDOFF->FREE after MIN_LOW cycles (down-counter loaded with MIN_LOW-1).
- result_ready[b] = (state[b]==READY), registered.
- Latency:
  - acc_done at cycle N -> result_ready high at N+1.
  - cpu_ack rise sampled at N -> result_ready low at N+1.
- Ack edge detection: ack_d <= cpu_ack; ack_rise = cpu_ack & ~ack_d. cpu_ack is same-clock, so no synchroniser.
- Grant rule:
  - At most one BUSY bank at any time.
  - Grant when acc_req=1, no bank BUSY, no grant pulse in the previous cycle, and state[wr_ptr]==FREE.
  - On grant, wr_ptr toggles. Strict round-robin: the non-pointed bank is never granted out of order, so CPU consumption order = production order.
- acc_stall = acc_req & ~grant_condition, registered.
- acc_done with no BUSY bank -> proto_err set, no state change.
- Simultaneous events in one cycle:
  - acc_done on bank A and ack on bank B: both take effect.
  - Ack on a FREE, BUSY or HOLDOFF bank -> ack_err set, ignored.
  - Grant and HOLDOFF expiry on the same bank: expiry takes effect first; grant is possible no earlier than the next cycle.
- Both banks READY: acc_stall asserts on any request. No overflow or data loss.
- Sticky errors clear only on reset.
- Reset mid-operation: all banks immediately FREE, ready bits drop, and an in-flight acc_done after reset counts as proto_err.

Optional Feature:
- Macro: KVAZAAR_RESULT_READY_TIMEOUT_EN.
- Defined:
  - Per-bank counter of width clog2(TIMEOUT_CYC)+1 runs while the bank is READY.
  - Reaching TIMEOUT_CYC sets timeout[b] (sticky). The bank stays READY and the counter saturates.
- Undefined: no counters; timeout tied to 2'b00.

Decomposition:
- Shared package kvazaar_rr_pkg holds:
  - bank_state_t enum (FREE, BUSY, READY, HOLDOFF)
  - NUM_BANKS_C = 2
  - MIN_LOW_DEFAULT = 2
- One natural sub-module, kvazaar_rr_bank: single-bank FSM, holdoff counter and optional watchdog, instantiated twice.
- Grant/round-robin logic and error flags stay in the top module.

Test Plan:
- Reset, acc_req=1 -> acc_grant=1 with acc_grant_bank=0 one cycle after request. Pulse acc_done -> result_ready=2'b01 next cycle.
- Ack sequence:
  - cpu_ack 00->01 -> result_ready=00 next cycle.
  - With acc_req held, bank 0 is not re-granted for MIN_LOW=2 cycles; the next grant goes to bank 1 (round-robin).
- Fill both banks without acking -> result_ready=2'b11. Third acc_req -> acc_stall=1, no grant until an ack plus 2 holdoff cycles.
- Protocol errors:
  - acc_done with no grant -> proto_err=1, result_ready unchanged.
  - cpu_ack rise on a FREE bank -> ack_err=1.
- Same-cycle acc_done(bank 1) and ack(bank 0) -> result_ready goes 01->10 in one cycle.
- With KVAZAAR_RESULT_READY_TIMEOUT_EN and TIMEOUT_CYC=16: leave bank 0 READY for 16 cycles -> timeout=2'b01. Assert reset_n=0 mid-BUSY -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/kvazaar_rr_pkg.sv
// Shared types and defaults for the ping-pong result-ready generator.
// Latency: n/a (declarations only). Backpressure: n/a.
// Optional watchdog macro: KVAZAAR_RESULT_READY_TIMEOUT_EN.
package kvazaar_rr_pkg;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        BUSY    = 2'd1,
        READY   = 2'd2,
        HOLDOFF = 2'd3
    } bank_state_t;

    localparam int NUM_BANKS_C     = 2;
    localparam int MIN_LOW_DEFAULT = 2;

endpackage

// File: rtl/kvazaar_rr_bank.sv
// Single result bank: FREE->BUSY->READY->HOLDOFF->FREE, with optional READY watchdog.
// Latency: ready follows done/ack_rise by one cycle. Backpressure: HOLDOFF keeps the bank ungrantable for MIN_LOW cycles.
// Optional watchdog macro: KVAZAAR_RESULT_READY_TIMEOUT_EN.
module kvazaar_rr_bank
    import kvazaar_rr_pkg::*;
#(
    parameter int MIN_LOW = MIN_LOW_DEFAULT
`ifdef KVAZAAR_RESULT_READY_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1048576
`endif
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        grant,
    input  logic        done,
    input  logic        ack_rise,
    output bank_state_t state,
    output logic        ready,
    output logic        timeout
);

    localparam int HW = $clog2(MIN_LOW);

    bank_state_t   state_d;
    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_d;

    always_comb begin
        state_d = state;
        hold_d  = hold_q;
        case (state)
            FREE:    if (grant) state_d = BUSY;
            BUSY:    if (done) state_d = READY;
            READY: begin
                if (ack_rise) begin
                    state_d = HOLDOFF;
                    hold_d  = HW'(MIN_LOW - 1);
                end
            end
            HOLDOFF: begin
                if (hold_q == '0) state_d = FREE;
                else              hold_d  = hold_q - HW'(1);
            end
            default: state_d = FREE;
        endcase
    end

    // ready is registered from the next state so it tracks the FSM with no extra cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= FREE;
            hold_q <= '0;
            ready  <= 1'b0;
        end else begin
            state  <= state_d;
            hold_q <= hold_d;
            ready  <= (state_d == READY);
        end
    end

`ifdef KVAZAAR_RESULT_READY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;

    logic [TW-1:0] wd_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_q    <= '0;
            timeout <= 1'b0;
        end else if (state == READY) begin
            if (wd_q != TW'(TIMEOUT_CYC)) wd_q <= wd_q + TW'(1);
            if (wd_q == TW'(TIMEOUT_CYC - 1)) timeout <= 1'b1;
        end else begin
            wd_q <= '0;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: rtl/kvazaar_result_ready_gen.sv
// Ping-pong result bank arbiter driving per-bank ready levels to the edge-capture PIO.
// Latency: grant 1 cycle after request; ready rises 1 cycle after acc_done, falls 1 cycle after ack edge.
// Backpressure: acc_stall while no bank is grantable; strict round-robin, no data loss. Macro: KVAZAAR_RESULT_READY_TIMEOUT_EN.
module kvazaar_result_ready_gen
    import kvazaar_rr_pkg::*;
#(
    parameter int NUM_BANKS = NUM_BANKS_C,
    parameter int MIN_LOW   = MIN_LOW_DEFAULT
`ifdef KVAZAAR_RESULT_READY_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 1048576
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 acc_req,
    output logic                 acc_grant,
    output logic                 acc_grant_bank,
    input  logic                 acc_done,
    input  logic [NUM_BANKS-1:0] cpu_ack,
    output logic [NUM_BANKS-1:0] result_ready,
    output logic                 acc_stall,
    output logic                 proto_err,
    output logic                 ack_err,
    output logic [NUM_BANKS-1:0] timeout
);

    bank_state_t          bank_state [NUM_BANKS];
    logic [NUM_BANKS-1:0] ack_d;
    logic [NUM_BANKS-1:0] ack_rise;
    logic [NUM_BANKS-1:0] busy_vec;
    logic [NUM_BANKS-1:0] ready_vec;
    logic [NUM_BANKS-1:0] grant_vec;
    logic [NUM_BANKS-1:0] done_vec;
    logic [NUM_BANKS-1:0] bank_ready;
    logic [NUM_BANKS-1:0] bank_timeout;
    logic                 wr_ptr;
    logic                 grant_cond;

    assign ack_rise = cpu_ack & ~ack_d;

    // only the pointed bank may be granted, keeping consumption order equal to production order
    always_comb begin
        busy_vec  = '0;
        ready_vec = '0;
        grant_vec = '0;
        grant_cond = acc_req & ~acc_grant & (bank_state[wr_ptr] == FREE);
        for (int b = 0; b < NUM_BANKS; b++) begin
            busy_vec[b]  = (bank_state[b] == BUSY);
            ready_vec[b] = (bank_state[b] == READY);
        end
        grant_cond = grant_cond & ~(|busy_vec);
        for (int b = 0; b < NUM_BANKS; b++) begin
            grant_vec[b] = grant_cond & (wr_ptr == 1'(b));
        end
        done_vec = acc_done ? busy_vec : '0;
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        kvazaar_rr_bank #(
            .MIN_LOW     (MIN_LOW)
`ifdef KVAZAAR_RESULT_READY_TIMEOUT_EN
            ,
            .TIMEOUT_CYC (TIMEOUT_CYC)
`endif
        ) u_bank (
            .clk      (clk),
            .reset_n  (reset_n),
            .grant    (grant_vec[b]),
            .done     (done_vec[b]),
            .ack_rise (ack_rise[b]),
            .state    (bank_state[b]),
            .ready    (bank_ready[b]),
            .timeout  (bank_timeout[b])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_d          <= '0;
            wr_ptr         <= 1'b0;
            acc_grant      <= 1'b0;
            acc_grant_bank <= 1'b0;
            acc_stall      <= 1'b0;
            proto_err      <= 1'b0;
            ack_err        <= 1'b0;
        end else begin
            ack_d     <= cpu_ack;
            acc_grant <= grant_cond;
            acc_stall <= acc_req & ~grant_cond;
            if (grant_cond) begin
                acc_grant_bank <= wr_ptr;
                wr_ptr         <= ~wr_ptr;
            end
            if (acc_done && !(|busy_vec)) proto_err <= 1'b1;
            if (|(ack_rise & ~ready_vec)) ack_err <= 1'b1;
        end
    end

    assign result_ready = bank_ready;
    assign timeout      = bank_timeout;

endmodule

// File: tb/tb_kvazaar_result_ready_gen.sv
// Directed bench for kvazaar_result_ready_gen with a timestamp-based reference model.
module tb_kvazaar_result_ready_gen;

    localparam int MIN_LOW = 2;
    localparam int TO_CYC  = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       acc_req;
    logic       acc_grant;
    logic       acc_grant_bank;
    logic       acc_done;
    logic [1:0] cpu_ack;
    logic [1:0] result_ready;
    logic       acc_stall;
    logic       proto_err;
    logic       ack_err;
    logic [1:0] timeout;

    int total = 0;
    int bad   = 0;

    kvazaar_result_ready_gen #(
        .MIN_LOW     (MIN_LOW)
`ifdef KVAZAAR_RESULT_READY_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (TO_CYC)
`endif
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .acc_req        (acc_req),
        .acc_grant      (acc_grant),
        .acc_grant_bank (acc_grant_bank),
        .acc_done       (acc_done),
        .cpu_ack        (cpu_ack),
        .result_ready   (result_ready),
        .acc_stall      (acc_stall),
        .proto_err      (proto_err),
        .ack_err        (ack_err),
        .timeout        (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: banks tracked by ready flags, the busy bank index and the
    // cycle from which a released bank may be granted again.
    int       cyc = 0;
    int       m_busy = -1;
    int       m_avail [2] = '{0, 0};
    int       rdy_from [2] = '{0, 0};
    bit [1:0] m_rdy = '0;
    bit [1:0] m_ackd = '0;
    bit       m_ptr = 1'b0;
    bit       m_glast = 1'b0;
    bit [1:0] e_rr = '0;
    bit [1:0] e_to = '0;
    bit       e_grant = 1'b0, e_gbank = 1'b0, e_stall = 1'b0, e_perr = 1'b0, e_aerr = 1'b0;

    initial forever begin : mdl
        bit [1:0] rise;
        bit [1:0] rdy_before;
        bit       g;
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            cyc = 0; m_busy = -1; m_avail = '{0, 0}; m_rdy = '0; m_ackd = '0;
            m_ptr = 0; m_glast = 0; e_rr = '0; e_to = '0;
            e_grant = 0; e_gbank = 0; e_stall = 0; e_perr = 0; e_aerr = 0;
        end else begin
            rise   = cpu_ack & ~m_ackd;
            m_ackd = cpu_ack;
            g = acc_req && (m_busy < 0) && !m_glast && !m_rdy[m_ptr] && (cyc >= m_avail[m_ptr]);
            rdy_before = m_rdy;
            if (acc_done) begin
                if (m_busy >= 0) begin
                    m_rdy[m_busy]    = 1'b1;
                    rdy_from[m_busy] = cyc + 1;
                    m_busy           = -1;
                end else begin
                    e_perr = 1'b1;
                end
            end
            for (int b = 0; b < 2; b++) begin
                if (rise[b]) begin
                    if (rdy_before[b]) begin
                        m_rdy[b]   = 1'b0;
                        m_avail[b] = cyc + 1 + MIN_LOW;
                    end else begin
                        e_aerr = 1'b1;
                    end
                end
`ifdef KVAZAAR_RESULT_READY_TIMEOUT_EN
                if (rdy_before[b] && (cyc - rdy_from[b] >= TO_CYC - 1)) e_to[b] = 1'b1;
`endif
            end
            if (g) begin
                m_busy  = int'(m_ptr);
                e_gbank = m_ptr;
                m_ptr   = ~m_ptr;
            end
            e_grant = g;
            m_glast = g;
            e_stall = acc_req && !g;
            e_rr    = m_rdy;
            cyc++;
        end
    end

    initial forever begin
        @(negedge clk);
        chk("m_ready", result_ready, e_rr);
        chk("m_grant", acc_grant, e_grant);
        if (e_grant) chk("m_gbank", acc_grant_bank, e_gbank);
        chk("m_stall", acc_stall, e_stall);
        chk("m_proto", proto_err, e_perr);
        chk("m_ackerr", ack_err, e_aerr);
        chk("m_timeout", timeout, e_to);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; acc_req = 1'b0; acc_done = 1'b0; cpu_ack = 2'b00;
        repeat (2) @(negedge clk);
        chk("rst_ready", result_ready, 0);
        chk("rst_grant", acc_grant, 0);
        chk("rst_gbank", acc_grant_bank, 0);
        chk("rst_stall", acc_stall, 0);
        chk("rst_proto", proto_err, 0);
        chk("rst_ackerr", ack_err, 0);
        chk("rst_timeout", timeout, 0);
        reset_n = 1'b1;
        @(negedge clk);

        acc_req = 1'b1;
        @(negedge clk);
        chk("grant0", acc_grant, 1);
        chk("grant0_bank", acc_grant_bank, 0);
        acc_req = 1'b0; acc_done = 1'b1;
        @(negedge clk);
        chk("ready_01", result_ready, 2'b01);
        acc_done = 1'b0; acc_req = 1'b1; cpu_ack = 2'b01;
        @(negedge clk);
        chk("ack0_ready", result_ready, 2'b00);
        chk("grant1", acc_grant, 1);
        chk("grant1_bank", acc_grant_bank, 1);
        acc_req = 1'b0; acc_done = 1'b1;
        @(negedge clk);
        chk("ready_10", result_ready, 2'b10);
        acc_done = 1'b0; acc_req = 1'b1;
        @(negedge clk);
        chk("holdoff_nogrant", acc_grant, 0);
        chk("holdoff_stall", acc_stall, 1);
        @(negedge clk);
        chk("regrant0", acc_grant, 1);
        chk("regrant0_bank", acc_grant_bank, 0);

        acc_req = 1'b0; acc_done = 1'b1;
        @(negedge clk);
        chk("ready_11", result_ready, 2'b11);
        acc_done = 1'b0; acc_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("full_stall", acc_stall, 1);
            chk("full_nogrant", acc_grant, 0);
        end
        cpu_ack = 2'b11;
        @(negedge clk);
        chk("ack1_ready", result_ready, 2'b01);
        chk("ack1_nogrant", acc_grant, 0);
        @(negedge clk);
        chk("ack1_hold_a", acc_grant, 0);
        @(negedge clk);
        chk("ack1_hold_b", acc_grant, 0);
        chk("ack1_hold_stall", acc_stall, 1);
        @(negedge clk);
        chk("rr_grant1", acc_grant, 1);
        chk("rr_grant1_bank", acc_grant_bank, 1);

        acc_req = 1'b0; cpu_ack = 2'b10;
        @(negedge clk);
        chk("pre_same", result_ready, 2'b01);
        cpu_ack = 2'b11; acc_done = 1'b1;
        @(negedge clk);
        chk("same_cycle", result_ready, 2'b10);
        chk("same_no_ackerr", ack_err, 0);

        @(negedge clk);
        chk("proto_err", proto_err, 1);
        chk("proto_ready", result_ready, 2'b10);
        acc_done = 1'b0; cpu_ack = 2'b10;
        repeat (4) @(negedge clk);
        cpu_ack = 2'b11;
        @(negedge clk);
        chk("ack_err", ack_err, 1);
        chk("ack_err_ready", result_ready, 2'b10);

        repeat (20) @(negedge clk);
`ifdef KVAZAAR_RESULT_READY_TIMEOUT_EN
        chk("timeout_b1", timeout[1], 1);
`else
        chk("timeout_off", timeout, 0);
`endif

        cpu_ack = 2'b00; acc_req = 1'b1;
        @(negedge clk);
        chk("busy_grant", acc_grant, 1);
        chk("busy_grant_bank", acc_grant_bank, 0);
        acc_req = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("arst_ready", result_ready, 0);
        chk("arst_grant", acc_grant, 0);
        chk("arst_proto", proto_err, 0);
        chk("arst_ackerr", ack_err, 0);
        chk("arst_timeout", timeout, 0);
        @(negedge clk);
        reset_n = 1'b1; acc_done = 1'b1;
        @(negedge clk);
        chk("post_rst_proto", proto_err, 1);
        chk("post_rst_ready", result_ready, 0);
        acc_done = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
